// File: rtl/ir_pulse_frontend.sv
// Synchronise, deglitch and time the IR line; emits (level, length) records, 1-cycle latency.
// One output register: a record arriving while the held one is not taken is dropped and flags overrun.
`timescale 1ns/1ps
module ir_pulse_frontend #(
    parameter int FILT_LEN = 3,
    parameter int CNT_W    = 16,
    parameter int IDLE_LEN = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irda,
    output logic             pulse_valid,
    input  logic             pulse_ready,
    output logic             pulse_level,
    output logic [CNT_W-1:0] pulse_len,
    output logic             pulse_last,
    output logic             overrun,
    output logic             idle
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0]    FILT_TOP = FW'(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] IDLE_CNT = CNT_W'(IDLE_LEN);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             filt_q, filt_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reported_q, reported_d;
    logic             pulse_valid_q, pulse_valid_d;
    logic             pulse_level_q, pulse_level_d;
    logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
    logic             pulse_last_q, pulse_last_d;
    logic             overrun_q, overrun_d;

    logic [FW-1:0]    fcnt_inc;
    logic             toggle;
    logic             rec_vld;
    logic             rec_lvl;
    logic [CNT_W-1:0] rec_len;
    logic             rec_last;

    always_comb begin
        s1_d     = irda;
        s2_d     = s1_q;
        fcnt_inc = fcnt_q + FW'(1);
        filt_d   = filt_q;
        fcnt_d   = '0;
        toggle   = 1'b0;
        if (s2_q != filt_q) begin
            if (fcnt_inc == FILT_TOP) begin
                filt_d = ~filt_q;
                toggle = 1'b1;
            end else begin
                fcnt_d = fcnt_inc;
            end
        end

        if (toggle) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A high period already closed by the timeout produces no record at its falling edge.
        rec_vld    = 1'b0;
        rec_lvl    = 1'b0;
        rec_len    = '0;
        rec_last   = 1'b0;
        reported_d = reported_q;
        if (toggle) begin
            reported_d = 1'b0;
            if (!reported_q) begin
                rec_vld = 1'b1;
                rec_lvl = filt_q;
                rec_len = cnt_q;
            end
        end else if (filt_q && !reported_q && cnt_q == IDLE_CNT) begin
            rec_vld    = 1'b1;
            rec_lvl    = 1'b1;
            rec_len    = IDLE_CNT;
            rec_last   = 1'b1;
            reported_d = 1'b1;
        end

        pulse_valid_d = pulse_valid_q & ~pulse_ready;
        pulse_level_d = pulse_level_q;
        pulse_len_d   = pulse_len_q;
        pulse_last_d  = pulse_last_q;
        overrun_d     = overrun_q;
        if (rec_vld) begin
            if (!pulse_valid_q || pulse_ready) begin
                pulse_valid_d = 1'b1;
                pulse_level_d = rec_lvl;
                pulse_len_d   = rec_len;
                pulse_last_d  = rec_last;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            filt_q        <= 1'b1;
            fcnt_q        <= '0;
            cnt_q         <= '0;
            reported_q    <= 1'b1;
            pulse_valid_q <= 1'b0;
            pulse_level_q <= 1'b0;
            pulse_len_q   <= '0;
            pulse_last_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            filt_q        <= filt_d;
            fcnt_q        <= fcnt_d;
            cnt_q         <= cnt_d;
            reported_q    <= reported_d;
            pulse_valid_q <= pulse_valid_d;
            pulse_level_q <= pulse_level_d;
            pulse_len_q   <= pulse_len_d;
            pulse_last_q  <= pulse_last_d;
            overrun_q     <= overrun_d;
        end
    end

    assign pulse_valid = pulse_valid_q;
    assign pulse_level = pulse_level_q;
    assign pulse_len   = pulse_len_q;
    assign pulse_last  = pulse_last_q;
    assign overrun     = overrun_q;
    assign idle        = filt_q & reported_q;

endmodule

// File: tb/tb_ir_pulse_frontend.sv
// Randomised line-segment stimulus against a period-level reference model with a record scoreboard.
`timescale 1ns/1ps
module tb_ir_pulse_frontend;

    localparam int FILT_LEN = 3;
    localparam int CNT_W    = 16;
    localparam int IDLE_LEN = 1000;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             irda = 1'b1;
    logic             pulse_ready = 1'b1;
    logic             pulse_valid;
    logic             pulse_level;
    logic [CNT_W-1:0] pulse_len;
    logic             pulse_last;
    logic             overrun;
    logic             idle;

    always #5 clk = ~clk;

    ir_pulse_frontend #(
        .FILT_LEN (FILT_LEN),
        .CNT_W    (CNT_W),
        .IDLE_LEN (IDLE_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irda        (irda),
        .pulse_valid (pulse_valid),
        .pulse_ready (pulse_ready),
        .pulse_level (pulse_level),
        .pulse_len   (pulse_len),
        .pulse_last  (pulse_last),
        .overrun     (overrun),
        .idle        (idle)
    );

    typedef struct {
        int lvl;
        int len;
        int last;
    } rec_t;

    rec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;

    // Reference model: the filtered line as a list of periods of the raw segments.
    int m_level, m_acc, m_rep;
    bit m_mute = 1'b0;

    function automatic void push_rec(int l, int n, int last);
        rec_t r;
        r.lvl = l; r.len = n; r.last = last;
        if (!m_mute) exp_q.push_back(r);
    endfunction

    function automatic void mdl_reset();
        m_level = 1; m_acc = 0; m_rep = 1;
    endfunction

    // A segment shorter than the filter length never changes the filtered level.
    function automatic void mdl_seg(int lvl, int n);
        if (lvl == m_level || n < FILT_LEN) begin
            m_acc += n;
        end else begin
            if (m_rep == 0) push_rec(m_level, (m_acc > SAT) ? SAT : m_acc, 0);
            m_rep = 0;
            m_level = lvl;
            m_acc = n;
        end
        if (m_level == 1 && m_rep == 0 && m_acc > IDLE_LEN) begin
            push_rec(1, IDLE_LEN, 1);
            m_rep = 1;
        end
    endfunction

    task automatic check(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive_seg(int lvl, int n);
        mdl_seg(lvl, n);
        irda = (lvl != 0);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(string name, int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !pulse_valid) break;
            mdl_seg(int'(irda), 1);
            @(posedge clk); #1;
        end
        n_chk++;
        if (i == budget) begin
            n_fail++;
            $display("FAIL %s: drain timed out, %0d records still expected, valid=%0d", name, exp_q.size(), pulse_valid);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_valid", int'(pulse_valid), 0);
        check("rst_level", int'(pulse_level), 0);
        check("rst_len", int'(pulse_len), 0);
        check("rst_last", int'(pulse_last), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_idle", int'(idle), 1);
        rst = 1'b0;
        mdl_reset();
    endtask

    // Ready driver: never more than two low cycles in a row except in mode 3.
    initial begin
        int run = 0;
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: begin
                    if (run >= 2) pulse_ready = 1'b1;
                    else pulse_ready = ($urandom_range(0, 2) != 0);
                    run = pulse_ready ? 0 : run + 1;
                end
                2: begin
                    pulse_ready = (ph == 2);
                    ph = (ph + 1) % 3;
                end
                3: pulse_ready = 1'b0;
                default: pulse_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops on every accepted record and watches held outputs for stability.
    initial begin
        rec_t e;
        bit   held = 1'b0;
        int   pl, pn, pt;
        forever begin
            @(negedge clk);
            if (!rst && held && pulse_valid) begin
                n_chk++;
                if (int'(pulse_level) != pl || int'(pulse_len) != pn || int'(pulse_last) != pt) begin
                    n_fail++;
                    $display("FAIL held_stable: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                             pulse_level, pulse_len, pulse_last, pl, pn, pt);
                end
            end
            if (!rst && pulse_valid && pulse_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_record: got (%0d,%0d,%0d), required none",
                             pulse_level, pulse_len, pulse_last);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(pulse_level) != e.lvl || int'(pulse_len) != e.len || int'(pulse_last) != e.last) begin
                        n_fail++;
                        $display("FAIL record: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                                 pulse_level, pulse_len, pulse_last, e.lvl, e.len, e.last);
                    end
                end
            end
            held = !rst && pulse_valid && !pulse_ready;
            pl = int'(pulse_level);
            pn = int'(pulse_len);
            pt = int'(pulse_last);
        end
    end

    initial begin
        int lat;
        int lvl;
        int n, a, g;

        rst = 1'b1;
        irda = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("init_valid", int'(pulse_valid), 0);
        check("init_len", int'(pulse_len), 0);
        check("init_overrun", int'(overrun), 0);
        check("init_idle", int'(idle), 1);
        rst = 1'b0;
        mdl_reset();

        // Idle line produces nothing.
        drive_seg(1, 2000);
        check("idle_valid", int'(pulse_valid), 0);
        check("idle_idle", int'(idle), 1);
        check("idle_overrun", int'(overrun), 0);

        // Single mark, latency, then timeout.
        drive_seg(0, 40);
        irda = 1'b1;
        mdl_seg(1, 1100);
        lat = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (pulse_valid) begin
                lat = i;
                break;
            end
        end
        check("rise_to_valid_cycles", lat, 2 + FILT_LEN);
        repeat (1100 - lat) begin
            @(posedge clk); #1;
        end
        check("timeout_idle", int'(idle), 1);

        // Glitches below the filter length.
        drive_seg(0, FILT_LEN - 1);
        drive_seg(1, 20);
        check("glitch_idle", int'(idle), 1);
        drive_seg(0, FILT_LEN);
        drive_seg(1, IDLE_LEN + 50);

        // Short frame.
        drive_seg(0, 90);
        drive_seg(1, 30);
        drive_seg(0, 50);
        drive_seg(1, IDLE_LEN + 50);
        check("frame_idle", int'(idle), 1);

        // Random frames under random bounded backpressure.
        rdy_mode = 1;
        lvl = 0;
        for (int k = 0; k < 24; k++) begin
            if (lvl == 1 && $urandom_range(0, 5) == 0) begin
                n = $urandom_range(995, 1200);
                if (n == IDLE_LEN) n = IDLE_LEN + 1;
                drive_seg(lvl, n);
            end else begin
                n = $urandom_range(3, 150);
                if (n >= 8 && $urandom_range(0, 3) == 0) begin
                    a = $urandom_range(3, n - 5);
                    g = $urandom_range(1, FILT_LEN - 1);
                    drive_seg(lvl, a);
                    drive_seg(1 - lvl, g);
                    drive_seg(lvl, n - a - g);
                end else begin
                    drive_seg(lvl, n);
                end
            end
            lvl = 1 - lvl;
        end
        drive_seg(1, IDLE_LEN + 50);

        // Minimum-length periods against a periodic ready, forcing accept-and-load.
        rdy_mode = 2;
        lvl = 0;
        for (int k = 0; k < 40; k++) begin
            drive_seg(lvl, $urandom_range(3, 4));
            lvl = 1 - lvl;
        end
        drive_seg(1, IDLE_LEN + 50);
        rdy_mode = 0;
        wait_drain("random_drain", 400);
        check("random_overrun", int'(overrun), 0);

        // Stalled consumer: later records are dropped, the held one is kept.
        rdy_mode = 3;
        drive_seg(1, 3);
        push_rec(0, 20, 0);
        m_mute = 1'b1;
        drive_seg(0, 20);
        drive_seg(1, 25);
        drive_seg(0, 30);
        drive_seg(1, 30);
        m_mute = 1'b0;
        check("stall_valid", int'(pulse_valid), 1);
        check("stall_level", int'(pulse_level), 0);
        check("stall_len", int'(pulse_len), 20);
        check("stall_last", int'(pulse_last), 0);
        check("stall_overrun", int'(overrun), 1);
        rdy_mode = 0;
        drive_seg(1, IDLE_LEN);
        wait_drain("stall_drain", 200);
        check("overrun_sticky", int'(overrun), 1);

        // Saturating length.
        drive_seg(0, SAT + 65);
        drive_seg(1, 20);
        drive_seg(0, 100);
        check("pre_reset_queue", exp_q.size(), 0);

        // Reset in the middle of a low period.
        do_reset();
        drive_seg(0, 30);
        drive_seg(1, IDLE_LEN + 50);
        check("post_reset_idle", int'(idle), 1);

        wait_drain("final_drain", 200);
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
